// File: rtl/nibble_loader_if.sv
// Nibble-stream and register-load signals between a feeder and nibble_loader.
// master drives the nibble stream; slave is the loader.
interface nibble_loader_if #(
  parameter int unsigned WIDTH = 8
);
  logic [3:0]       in_nib;
  logic             in_valid;
  logic             in_ready;
  logic             in_par;
  logic             flush;
  logic [WIDTH-1:0] ld_d;
  logic             ld_en;
  logic             busy;
  logic [7:0]       words;
  logic             par_err;

  modport master (
    output in_nib, in_valid, in_par, flush,
    input  in_ready, ld_d, ld_en, busy, words, par_err
  );

  modport slave (
    input  in_nib, in_valid, in_par, flush,
    output in_ready, ld_d, ld_en, busy, words, par_err
  );
endinterface

// File: rtl/nibble_loader.sv
// Assembles WIDTH-bit words from a MSN-first nibble stream and strobes each onto ld_d/ld_en.
// Optional odd-parity check on completed words is enabled by NIBBLE_LOADER_PARITY_EN.
module nibble_loader #(
  parameter int unsigned WIDTH = 8
) (
  input logic            clk,
  input logic            clr,
  nibble_loader_if.slave bus
);
  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned CntW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NIBBLES - 1);

  typedef enum logic [0:0] {StCollect, StStrobe} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] ld_d_q, ld_d_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [7:0]       words_q, words_d;
  logic             par_err_q, par_err_d;

  logic [WIDTH+3:0] cat;
  logic [WIDTH-1:0] word;
  logic             xfer;
  logic             last;
  logic             par_ok;

  // Concatenate then truncate so WIDTH=4 needs no special case.
  assign cat  = {shift_q, bus.in_nib};
  assign word = cat[WIDTH-1:0];
  assign xfer = bus.in_valid && (state_q == StCollect) && !bus.flush;
  assign last = xfer && (cnt_q == LastCnt);

`ifdef NIBBLE_LOADER_PARITY_EN
  assign par_ok = (^word) ^ bus.in_par;
`else
  logic unused_in_par;
  assign unused_in_par = bus.in_par;
  assign par_ok        = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    ld_d_d    = ld_d_q;
    words_d   = words_q;
    par_err_d = par_err_q;
    unique case (state_q)
      StCollect: begin
        if (bus.flush) begin
          shift_d   = '0;
          cnt_d     = '0;
          par_err_d = 1'b0;
        end else if (xfer) begin
          shift_d = word;
          if (last) begin
            cnt_d = '0;
            if (par_ok) begin
              ld_d_d  = word;
              state_d = StStrobe;
            end else begin
              par_err_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StStrobe: begin
        words_d = words_q + 8'd1;
        state_d = StCollect;
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= StCollect;
      shift_q   <= '0;
      cnt_q     <= '0;
      ld_d_q    <= '0;
      words_q   <= '0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      ld_d_q    <= ld_d_d;
      words_q   <= words_d;
      par_err_q <= par_err_d;
    end
  end

  assign bus.in_ready = (state_q == StCollect);
  assign bus.ld_en    = (state_q == StStrobe);
  assign bus.busy     = (cnt_q != '0) || (state_q == StStrobe);
  assign bus.ld_d     = ld_d_q;
  assign bus.words    = words_q;
  assign bus.par_err  = par_err_q;
endmodule

// File: tb/tb_nibble_loader.sv
// Scoreboard bench for nibble_loader: a nibble-list model predicts words and strobe cycles,
// and an independent monitor checks every strobe and ld_d stability.
module tb_nibble_loader;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned NIBBLES = WIDTH / 4;

  typedef struct {
    logic [WIDTH-1:0] word;
    int               words;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b1;

  nibble_loader_if #(.WIDTH(WIDTH)) bus ();

  nibble_loader #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] mon_last = '0;
  bit               mon_en   = 1'b0;

  bit         m_strobe  = 1'b0;
  logic [3:0] m_nibs[$];
  int         m_words   = 0;
  bit         m_par_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit par_ok(input logic [WIDTH-1:0] w, input bit p);
`ifdef NIBBLE_LOADER_PARITY_EN
    return ((^w) ^ p) == 1'b1;
`else
    return 1'b1;
`endif
  endfunction

  exp_t mon_e;
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.ld_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_data", 32'(bus.ld_d), 32'(mon_e.word));
          check("strobe_words", 32'(bus.words), 32'(mon_e.words));
          check("strobe_cycle", cyc, mon_e.cyc);
          check("strobe_ready_low", 32'(bus.in_ready), 32'd0);
          mon_last = mon_e.word;
        end
      end else begin
        check("ld_d_hold", 32'(bus.ld_d), 32'(mon_last));
      end
    end
  end

  // One clock of stimulus, then advance the model and compare status outputs.
  task automatic step(input bit c, input bit v, input logic [3:0] n, input bit p, input bit f,
                      output bit acc);
    logic [WIDTH-1:0] w;
    exp_t e;
    clr          = c;
    bus.in_valid = v;
    bus.in_nib   = n;
    bus.in_par   = p;
    bus.flush    = f;
    @(posedge clk);
    #1;
    acc = 1'b0;
    if (c) begin
      m_strobe  = 1'b0;
      m_nibs.delete();
      m_words   = 0;
      m_par_err = 1'b0;
      exp_q.delete();
      mon_last  = '0;
      mon_en    = 1'b1;
    end else if (m_strobe) begin
      m_strobe = 1'b0;
      m_words  = (m_words + 1) % 256;
    end else if (f) begin
      m_nibs.delete();
      m_par_err = 1'b0;
    end else if (v) begin
      acc = 1'b1;
      m_nibs.push_back(n);
      if (m_nibs.size() == NIBBLES) begin
        w = '0;
        foreach (m_nibs[i]) w = (w << 4) | WIDTH'(m_nibs[i]);
        m_nibs.delete();
        if (par_ok(w, p)) begin
          e.word  = w;
          e.words = m_words;
          e.cyc   = cyc;
          exp_q.push_back(e);
          m_strobe = 1'b1;
        end else begin
          m_par_err = 1'b1;
        end
      end
    end
    check("in_ready", 32'(bus.in_ready), 32'(!m_strobe));
    check("busy", 32'(bus.busy), 32'((m_nibs.size() != 0) || m_strobe));
    check("words", 32'(bus.words), 32'(m_words));
    check("par_err", 32'(bus.par_err), 32'(m_par_err));
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, acc);
  endtask

  // Holds in_valid high, re-presenting each nibble until the model says it transferred.
  task automatic stream(input logic [3:0] nibs[$], input bit p);
    bit acc;
    int budget;
    budget = 4 * nibs.size() + 4;
    while (nibs.size() != 0 && budget > 0) begin
      step(1'b0, 1'b1, nibs[0], p, 1'b0, acc);
      if (acc) void'(nibs.pop_front());
      budget--;
    end
    if (nibs.size() != 0) check("stream_budget", 32'(nibs.size()), 32'd0);
  endtask

  initial begin
    logic [3:0] q[$];
    bit acc;
    bus.in_valid = 1'b0;
    bus.in_nib   = 4'h0;
    bus.in_par   = 1'b0;
    bus.flush    = 1'b0;

    // Reset, then reset again with one nibble held.
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, acc);
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, acc);
    step(1'b0, 1'b1, 4'h7, 1'b0, 1'b0, acc);
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, acc);
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, acc);
    check("reset_ld_d", 32'(bus.ld_d), 32'h0);
    check("reset_ld_en", 32'(bus.ld_en), 32'h0);

    // Single word, then streaming.
    q = '{4'hA, 4'h5};
    stream(q, 1'b0);
    idle(2);
    check("single_ld_d", 32'(bus.ld_d), 32'hA5);
    q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    stream(q, 1'b0);
    idle(2);

    // Flush collides with a valid nibble; later a flush during STROBE is ignored.
    q = '{4'hF};
    stream(q, 1'b0);
    step(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, acc);
    q = '{4'h3, 4'hC};
    stream(q, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, acc);
    idle(1);
    check("flush_ld_d", 32'(bus.ld_d), 32'h3C);

    // Random traffic with occasional flush and clr.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, 4'($urandom),
           1'($urandom), $urandom_range(0, 29) == 0, acc);
    end

    // Counter wrap: 257 back-to-back words.
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, acc);
    q.delete();
    for (int i = 0; i < 257 * NIBBLES; i++) q.push_back(4'($urandom));
    stream(q, 1'b0);
    idle(1);
    check("wrap_words", 32'(bus.words), 32'd1);

`ifdef NIBBLE_LOADER_PARITY_EN
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, acc);
    q = '{4'h0, 4'h1};
    stream(q, 1'b0);
    idle(1);
    q = '{4'h0, 4'h3};
    stream(q, 1'b0);
    idle(3);
    check("par_err_set", 32'(bus.par_err), 32'd1);
    check("par_ld_d_kept", 32'(bus.ld_d), 32'h01);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, acc);
    check("par_err_flushed", 32'(bus.par_err), 32'd0);
`endif

    idle(4);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
